keypad_scanner_4x4: RTL
=======================

KEYPAD_SCANNER_4X4 -- requirements
Module: keypad_scanner_4x4

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles each row is driven during scanning (legal range >=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8, consecutive matching samples needed to accept a press or a release (legal range >=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 row  output  4  one-hot active-high row drive; row[i] selects keypad row i.
REQ-006 col  input  4  active-high column sense for the driven row; already synchronised externally.
REQ-007 key_onehot  output  16  one-hot code of the last accepted key, bit index = 4*row_index + col_index; feeds the downstream 16-to-4 encoder.
REQ-008 key_valid  output  1  one-cycle strobe marking a newly accepted press.
REQ-009 key_held  output  1  level, high from an accepted press until its accepted release.
REQ-010 key_release  output  1  one-cycle strobe marking an accepted release.

Function
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, PRESSED and RELEASE; all outputs SHALL be registered.
REQ-012 SCAN: drive the current row for SCAN_DIV cycles and sample col only in the last dwell cycle.
REQ-013 SCAN sample == 0: advance the row 0001->0010->0100->1000->0001 (wrap) and restart the dwell.
REQ-014 SCAN sample with two or more bits set: treat as invalid, with no capture and a normal row advance.
REQ-015 SCAN sample exactly one-hot: capture the row and col indices, hold the row, enter DEBOUNCE with the match count at 0.
REQ-016 DEBOUNCE: each cycle after entry, col == captured one-hot increments the count; any other value returns to SCAN on the same row with the dwell restarted and no output change.
REQ-017 DEBOUNCE_CYCLES consecutive matches SHALL enter PRESSED; in the next cycle, key_onehot = 1<<(4*r+c), key_valid = 1 for exactly one cycle, and key_held = 1.
REQ-018 PRESSED: hold the row; the first col != captured one-hot enters RELEASE with the count at 0.
REQ-019 RELEASE: each col == 0 sample increments the count; col == captured one-hot returns to PRESSED; any other nonzero value resets the count and stays in RELEASE.
REQ-020 DEBOUNCE_CYCLES consecutive zero samples SHALL give key_release = 1 for one cycle and key_held = 0, advance to the next row, and enter SCAN.
REQ-021 key_onehot SHALL hold the last accepted key after release and change only on the next accepted press.
REQ-022 key_onehot SHALL always be all-zero or exactly one-hot.
REQ-023 key_valid and key_release SHALL never be asserted in the same cycle.
REQ-024 No new key SHALL be accepted while key_held = 1 (no rollover).

Reset
REQ-025 rst_n low at a clock edge SHALL, in any state including mid-debounce or PRESSED, set state=SCAN, row=0001, dwell and count=0, key_onehot=16'h0000, key_valid=0, key_held=0, key_release=0.
REQ-026 The first dwell after rst_n goes high SHALL begin on row 0001.

Verification (SCAN_DIV=2, DEBOUNCE_CYCLES=4)
REQ-027 Hold rst_n=0 for 2 cycles, col=0 -> row=0001, all outputs 0; after release, row steps 0001,0001,0010,0010,0100,... every 2 cycles.
REQ-028 Key 6 (col=0100 while row==0010, else 0) -> exactly one key_valid pulse, key_onehot=16'h0040, key_held=1, row frozen at 0010; downstream encoder yields 4'd6.
REQ-029 Bounce: col=0100 for 2 DEBOUNCE samples then 0 -> no key_valid, key_onehot unchanged, scanning resumes from row 0010.
REQ-030 Two keys in one row (col=0011 while row==0001) -> key_valid never asserts; rows keep cycling with wrap 1000->0001.
REQ-031 Key 15 held, then col=0 for 4 cycles -> key_release one-cycle pulse, key_held=0, key_onehot stays 16'h8000, next row 0001.
REQ-032 rst_n pulsed low for 1 cycle while key_held=1 -> all outputs cleared at that edge; a re-press is re-debounced before key_valid.

Source files
------------

// File: rtl/keypad_scanner_4x4_if.sv
// Row drive, column sense and key-event signals between the 4x4 scanner
// and its keypad/consumer side.
interface keypad_scanner_4x4_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_onehot;
  logic        key_valid;
  logic        key_held;
  logic        key_release;

  modport master (
    output row,
    output key_onehot,
    output key_valid,
    output key_held,
    output key_release,
    input  col
  );

  modport slave (
    input  row,
    input  key_onehot,
    input  key_valid,
    input  key_held,
    input  key_release,
    output col
  );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: row-by-row scan, press/release debounce,
// single-key acceptance with one-hot key code and press/release strobes.
module keypad_scanner_4x4 #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keypad_scanner_4x4_if.master   kp
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      cap_col_q, cap_col_d;
  logic [15:0]     key_q, key_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            release_q, release_d;

  function automatic logic [1:0] enc4(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] next_row(input logic [3:0] r);
    return {r[2:0], r[3]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      row_q     <= 4'b0001;
      dwell_q   <= '0;
      count_q   <= '0;
      cap_col_q <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      count_q   <= count_d;
      cap_col_q <= cap_col_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    count_d   = count_q;
    cap_col_d = cap_col_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    release_d = 1'b0;

    unique case (state_q)
      SCAN: begin
        // Columns are only trusted in the last cycle of the row dwell.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if ($onehot(kp.col)) begin
            cap_col_d = kp.col;
            count_d   = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_d = next_row(row_q);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (kp.col == cap_col_q) begin
          if (count_q == COUNT_LAST) begin
            count_d = '0;
            state_d = PRESSED;
            key_d   = 16'h0001 << {enc4(row_q), enc4(cap_col_q)};
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = SCAN;
          dwell_d = '0;
        end
      end

      PRESSED: begin
        if (kp.col != cap_col_q) begin
          count_d = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (kp.col == 4'b0000) begin
          if (count_q == COUNT_LAST) begin
            count_d   = '0;
            release_d = 1'b1;
            held_d    = 1'b0;
            row_d     = next_row(row_q);
            dwell_d   = '0;
            state_d   = SCAN;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else if (kp.col == cap_col_q) begin
          state_d = PRESSED;
        end else begin
          count_d = '0;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  assign kp.row         = row_q;
  assign kp.key_onehot  = key_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_held    = held_q;
  assign kp.key_release = release_q;

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid_q && release_q));
  a_key_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(key_q));

endmodule
